// File: rtl/freq_gate_counter.sv
// Counts synchronised rising edges of pulse_in over a GATE_CYCLES window and hands the count over valid/ready.
// Define FREQ_GATE_CONTINUOUS_EN to re-arm the gate straight after each result handshake.
module freq_gate_counter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pulse_in,
  input  logic                 start,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] result,
  output logic                 overflow,
  output logic                 result_valid,
  input  logic                 result_ready
);

  localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] GATE_LOAD = TW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    DONE
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   edge_det;
  logic [TW-1:0]          timer_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   result_q;
  logic                   overflow_q;
  logic                   valid_q;
  logic                   busy_q;

  // Edge detection runs in every state so a level already high at gate start is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~dly_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (edge_det) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      timer_q    <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= GATE;
            busy_q  <= 1'b1;
            timer_q <= GATE_LOAD;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        GATE: begin
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
          // timer_q == 0 marks the last counted cycle; its edge lands in the result.
          if (timer_q == '0) begin
            state_q    <= DONE;
            result_q   <= cnt_d;
            overflow_q <= ovf_d;
            valid_q    <= 1'b1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            valid_q <= 1'b0;
`ifdef FREQ_GATE_CONTINUOUS_EN
            state_q <= GATE;
            timer_q <= GATE_LOAD;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`else
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign overflow     = overflow_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: 16-bit and 4-bit instances share stimulus; counts are predicted from a pulse history log.
module tb_freq_gate_counter;

  localparam int G  = 100;
  localparam int S  = 2;
  localparam int HN = 8192;
`ifdef FREQ_GATE_CONTINUOUS_EN
  localparam int CONT = 1;
`else
  localparam int CONT = 0;
`endif

  logic        clk;
  logic        rst;
  logic        pulse_in;
  logic        start;
  logic        result_ready;
  logic        busy, overflow, result_valid;
  logic [15:0] result;
  logic        busy4, overflow4, result_valid4;
  logic [3:0]  result4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit hist [HN];
  int pmode    = 0;
  int per      = 10;
  int ph       = 0;
  int last16   = 0;
  int last4    = 0;

  freq_gate_counter #(.GATE_CYCLES(G), .CNT_WIDTH(16), .SYNC_STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .start(start), .busy(busy),
    .result(result), .overflow(overflow), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  freq_gate_counter #(.GATE_CYCLES(G), .CNT_WIDTH(4), .SYNC_STAGES(S)) u_dut4 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .start(start), .busy(busy4),
    .result(result4), .overflow(overflow4), .result_valid(result_valid4),
    .result_ready(result_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Log the pulse level seen at each edge; hist[n] is what the first sync flop captures at edge n.
  always @(posedge clk) begin
    if (cyc < HN) hist[cyc] <= pulse_in;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    case (pmode)
      1: begin
        pulse_in = (ph < per / 2);
        ph = (ph + 1) % per;
      end
      2: if ($urandom_range(0, 2) == 0) pulse_in = ~pulse_in;
      default: pulse_in = 1'b0;
    endcase
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // A rise logged at edge n is counted at edge n+S, so the window covers rises with s+1 <= n+S <= s+G.
  function automatic int count_edges(input int s);
    int c = 0;
    for (int n = s + 1 - S; n <= s + G - S; n++) begin
      if (n >= 1 && hist[n] && !hist[n-1]) c++;
    end
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic issue_start(output int s);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input int s, input string tag);
    int c;
    @(negedge clk);
    while (cyc < s + G) @(negedge clk);
    check({tag, "_vld_early"}, 32'(result_valid), 0);
    @(negedge clk);
    c = count_edges(s);
    last16 = (c > 65535) ? 65535 : c;
    last4  = (c > 15) ? 15 : c;
    check({tag, "_vld"}, 32'(result_valid), 1);
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_res"}, 32'(result), last16);
    check({tag, "_ovf"}, 32'(overflow), (c > 65535) ? 1 : 0);
    check({tag, "_vld4"}, 32'(result_valid4), 1);
    check({tag, "_res4"}, 32'(result4), last4);
    check({tag, "_ovf4"}, 32'(overflow4), (c > 15) ? 1 : 0);
  endtask

  task automatic handshake(output int h, input bit st);
    @(negedge clk);
    result_ready = 1'b1;
    start = st;
    @(posedge clk);
    h = cyc;
    @(negedge clk);
    result_ready = 1'b0;
    start = 1'b0;
    check("hs_vld", 32'(result_valid), 0);
    check("hs_busy", 32'(busy), CONT);
    check("hs_res_hold", 32'(result), last16);
    check("hs_vld4", 32'(result_valid4), 0);
  endtask

  initial begin
    int s, s2, h;
    rst = 1'b1;
    start = 1'b0;
    result_ready = 1'b0;

    // Reset state, then idle with a toggling input.
    pmode = 2;
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_vld", 32'(result_valid), 0);
    check("rst_res", 32'(result), 0);
    check("rst_ovf", 32'(overflow), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_vld", 32'(result_valid), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_res", 32'(result), 0);
    end

    // Period-10 train, consumer always ready: one-cycle valid carrying 10.
    pmode = 1; per = 10; ph = 0;
    do_reset();
    result_ready = 1'b1;
    issue_start(s);
    wait_result(s, "p10");
    check("p10_const", 32'(result), 10);
    @(negedge clk);
    check("p10_vld_drop", 32'(result_valid), 0);
    check("p10_busy_after", 32'(busy), CONT);
    check("p10_res_keep", 32'(result), 10);
    result_ready = 1'b0;

    // Period-4 train: 25 edges saturate the 4-bit instance.
    pmode = 1; per = 4; ph = 0;
    do_reset();
    result_ready = 1'b1;
    issue_start(s);
    wait_result(s, "p4");
    check("p4_res4_const", 32'(result4), 15);
    check("p4_ovf4_const", 32'(overflow4), 1);
    check("p4_res16_const", 32'(result), 25);
    result_ready = 1'b0;

    // Consumer stalls: result must hold and extra starts must not open a gate.
    pmode = 2;
    do_reset();
    issue_start(s);
    wait_result(s, "hold");
    for (int i = 0; i < 30; i++) begin
      check("hold_res", 32'(result), last16);
      check("hold_vld", 32'(result_valid), 1);
      check("hold_busy", 32'(busy), 1);
      check("hold_res4", 32'(result4), last4);
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    handshake(h, 1'b1);
    @(negedge clk);
    check("hold_start_dropped", 32'(busy), CONT);

    // Reset in the middle of a gate discards everything; a fresh gate still sees a full window.
    pmode = 1; per = 10; ph = 0;
    do_reset();
    result_ready = 1'b1;
    issue_start(s);
    wait_result(s, "pre_abort");
    if (CONT == 0) issue_start(s2);
    else s2 = s + G + 1;
    while (cyc < s2 + 50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_vld", 32'(result_valid), 0);
    check("abort_res", 32'(result), 0);
    check("abort_ovf", 32'(overflow), 0);
    check("abort_res4", 32'(result4), 0);
    repeat (5) @(negedge clk);
    issue_start(s);
    wait_result(s, "post_abort");
    check("post_abort_const", 32'(result), 10);
    result_ready = 1'b0;

    // Random trains with random consumer stalls.
    pmode = 2;
    do_reset();
    h = 0;
    for (int it = 0; it < 6; it++) begin
      if (CONT == 0 || it == 0) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        issue_start(s);
      end else begin
        s = h;
      end
      wait_result(s, "rand");
      repeat ($urandom_range(0, 5)) @(negedge clk);
      handshake(h, 1'($urandom_range(0, 1)));
    end

`ifdef FREQ_GATE_CONTINUOUS_EN
    // One start gives back-to-back windows while the consumer stays ready.
    pmode = 1; per = 10; ph = 0;
    do_reset();
    result_ready = 1'b1;
    issue_start(s);
    for (int k = 0; k < 3; k++) begin
      wait_result(s, "cont");
      check("cont_const", 32'(result), 10);
      s = s + G + 1;
    end
    result_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
